// File: rtl/cen_mean_ctrl.sv
// ---------------------------------------------------------------------------
// cen_mean_ctrl
// Sequencer for the four-channel centering accumulator in the FastICA front
// end. Streams 2^LOG2N four-channel samples into an external enable-cleared
// accumulator, then registers the per-channel means (sum >>> LOG2N, floor).
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   start, abort            pass control (abort has priority)
//   s_valid/s_ready, s_x*   sample stream in
//   acc_en, acc_x*          accumulator enable (low clears) and gated inputs
//   acc_sum*                accumulator sums back from the accumulator
//   mean*, mean_valid       registered means and their level-valid flag
//   done                    one-cycle pulse on entry to DONE
//   busy                    high in CLR, ACC, FLUSH
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | accumulator held clear, waiting for start
// CLR   | one-cycle clear before a restart from DONE
// ACC   | accepting samples, cnt counts transfers up to 2^LOG2N
// FLUSH | sums include last sample; means captured here
// DONE  | means valid, sums frozen, waiting for start (restart via CLR)
// ---------------------------------------------------------------------------
module cen_mean_ctrl #(
    parameter int DW    = 26,
    parameter int SW    = 40,
    parameter int LOG2N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_x1,
    input  logic signed [DW-1:0] s_x2,
    input  logic signed [DW-1:0] s_x3,
    input  logic signed [DW-1:0] s_x4,
    output logic                 acc_en,
    output logic signed [DW-1:0] acc_x1,
    output logic signed [DW-1:0] acc_x2,
    output logic signed [DW-1:0] acc_x3,
    output logic signed [DW-1:0] acc_x4,
    input  logic signed [SW-1:0] acc_sum1,
    input  logic signed [SW-1:0] acc_sum2,
    input  logic signed [SW-1:0] acc_sum3,
    input  logic signed [SW-1:0] acc_sum4,
    output logic signed [DW-1:0] mean1,
    output logic signed [DW-1:0] mean2,
    output logic signed [DW-1:0] mean3,
    output logic signed [DW-1:0] mean4,
    output logic                 mean_valid,
    output logic                 done,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ACC,
        S_FLUSH,
        S_DONE
    } state_t;

    // cnt value before the transfer that completes the pass
    localparam logic [LOG2N:0] LP_LAST = (LOG2N+1)'((1 << LOG2N) - 1);

    state_t               r_state;
    logic [LOG2N:0]       r_cnt;
    logic signed [DW-1:0] r_mean1;
    logic signed [DW-1:0] r_mean2;
    logic signed [DW-1:0] r_mean3;
    logic signed [DW-1:0] r_mean4;
    logic                 r_mean_valid;
    logic                 r_done;
    logic                 w_xfer;
    logic                 w_unused_sums;

    assign s_ready = (r_state == S_ACC);
    assign w_xfer  = s_valid & s_ready;
    assign acc_en  = (r_state == S_ACC) || (r_state == S_FLUSH) || (r_state == S_DONE);
    assign busy    = (r_state == S_CLR) || (r_state == S_ACC) || (r_state == S_FLUSH);

    // Zero on non-transfer cycles so the enabled accumulator holds its sum.
    assign acc_x1 = w_xfer ? s_x1 : '0;
    assign acc_x2 = w_xfer ? s_x2 : '0;
    assign acc_x3 = w_xfer ? s_x3 : '0;
    assign acc_x4 = w_xfer ? s_x4 : '0;

    assign mean1      = r_mean1;
    assign mean2      = r_mean2;
    assign mean3      = r_mean3;
    assign mean4      = r_mean4;
    assign mean_valid = r_mean_valid;
    assign done       = r_done;

    // Sum bits outside the mean window are never needed: with LOG2N <= SW-DW
    // the top bits are pure sign extension and the low bits are the fraction.
    assign w_unused_sums = ^{acc_sum1, acc_sum2, acc_sum3, acc_sum4};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mean1      <= '0;
            r_mean2      <= '0;
            r_mean3      <= '0;
            r_mean4      <= '0;
            r_mean_valid <= 1'b0;
            r_done       <= 1'b0;
        end else if (abort) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mean_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ACC;
                        r_cnt   <= '0;
                    end
                end
                S_CLR: begin
                    r_cnt   <= '0;
                    r_state <= S_ACC;
                end
                S_ACC: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt + (LOG2N+1)'(1);
                        if (r_cnt == LP_LAST) begin
                            r_state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    // Arithmetic shift right by LOG2N, floor rounding.
                    r_mean1      <= acc_sum1[LOG2N+DW-1:LOG2N];
                    r_mean2      <= acc_sum2[LOG2N+DW-1:LOG2N];
                    r_mean3      <= acc_sum3[LOG2N+DW-1:LOG2N];
                    r_mean4      <= acc_sum4[LOG2N+DW-1:LOG2N];
                    r_mean_valid <= 1'b1;
                    r_done       <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    if (start) begin
                        r_state      <= S_CLR;
                        r_mean_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cen_mean_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cen_mean_ctrl
// Bench for cen_mean_ctrl: one instance with LOG2N=2 for functional cases and
// one with LOG2N=14 for the full-range no-overflow passes. Each instance
// drives a behavioural enable-cleared accumulator. Expected means are pushed
// to a queue when a pass is launched and popped when done pulses.
// ---------------------------------------------------------------------------
module tb_cen_mean_ctrl;

    localparam int NB = 1 << 14;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---- instance A: LOG2N = 2
    logic               a_start, a_abort, a_s_valid, a_s_ready, a_acc_en;
    logic signed [25:0] a_x1, a_x2, a_x3, a_x4;
    logic signed [25:0] a_ax1, a_ax2, a_ax3, a_ax4;
    logic signed [39:0] a_sum1, a_sum2, a_sum3, a_sum4;
    logic signed [25:0] a_m1, a_m2, a_m3, a_m4;
    logic               a_mv, a_done, a_busy;

    // ---- instance B: LOG2N = 14
    logic               b_start, b_abort, b_s_valid, b_s_ready, b_acc_en;
    logic signed [25:0] b_x1, b_x2, b_x3, b_x4;
    logic signed [25:0] b_ax1, b_ax2, b_ax3, b_ax4;
    logic signed [39:0] b_sum1, b_sum2, b_sum3, b_sum4;
    logic signed [25:0] b_m1, b_m2, b_m3, b_m4;
    logic               b_mv, b_done, b_busy;

    cen_mean_ctrl #(.DW(26), .SW(40), .LOG2N(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
        .s_valid(a_s_valid), .s_ready(a_s_ready),
        .s_x1(a_x1), .s_x2(a_x2), .s_x3(a_x3), .s_x4(a_x4),
        .acc_en(a_acc_en),
        .acc_x1(a_ax1), .acc_x2(a_ax2), .acc_x3(a_ax3), .acc_x4(a_ax4),
        .acc_sum1(a_sum1), .acc_sum2(a_sum2), .acc_sum3(a_sum3), .acc_sum4(a_sum4),
        .mean1(a_m1), .mean2(a_m2), .mean3(a_m3), .mean4(a_m4),
        .mean_valid(a_mv), .done(a_done), .busy(a_busy)
    );

    cen_mean_ctrl #(.DW(26), .SW(40), .LOG2N(14)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
        .s_valid(b_s_valid), .s_ready(b_s_ready),
        .s_x1(b_x1), .s_x2(b_x2), .s_x3(b_x3), .s_x4(b_x4),
        .acc_en(b_acc_en),
        .acc_x1(b_ax1), .acc_x2(b_ax2), .acc_x3(b_ax3), .acc_x4(b_ax4),
        .acc_sum1(b_sum1), .acc_sum2(b_sum2), .acc_sum3(b_sum3), .acc_sum4(b_sum4),
        .mean1(b_m1), .mean2(b_m2), .mean3(b_m3), .mean4(b_m4),
        .mean_valid(b_mv), .done(b_done), .busy(b_busy)
    );

    // ---- behavioural accumulators: clear while En low, add every En cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !a_acc_en) begin
            a_sum1 <= '0; a_sum2 <= '0; a_sum3 <= '0; a_sum4 <= '0;
        end else begin
            a_sum1 <= a_sum1 + {{14{a_ax1[25]}}, a_ax1};
            a_sum2 <= a_sum2 + {{14{a_ax2[25]}}, a_ax2};
            a_sum3 <= a_sum3 + {{14{a_ax3[25]}}, a_ax3};
            a_sum4 <= a_sum4 + {{14{a_ax4[25]}}, a_ax4};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !b_acc_en) begin
            b_sum1 <= '0; b_sum2 <= '0; b_sum3 <= '0; b_sum4 <= '0;
        end else begin
            b_sum1 <= b_sum1 + {{14{b_ax1[25]}}, b_ax1};
            b_sum2 <= b_sum2 + {{14{b_ax2[25]}}, b_ax2};
            b_sum3 <= b_sum3 + {{14{b_ax3[25]}}, b_ax3};
            b_sum4 <= b_sum4 + {{14{b_ax4[25]}}, b_ax4};
        end
    end

    int           total = 0;
    int           bad   = 0;
    int           smp[4][4];
    logic [103:0] qa[$];
    logic [103:0] qb[$];
    logic [103:0] last_a;

    function automatic longint floordiv(input longint s, input longint n);
        longint q;
        q = s / n;
        if ((s % n != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a_start = 0; a_abort = 0; a_s_valid = 0; a_x1 = 0; a_x2 = 0; a_x3 = 0; a_x4 = 0;
        b_start = 0; b_abort = 0; b_s_valid = 0; b_x1 = 0; b_x2 = 0; b_x3 = 0; b_x4 = 0;
        repeat (2) @(negedge clk);
        total++;
        if ({a_acc_en, a_s_ready, a_mv, a_done, a_busy} !== 5'b0) begin
            bad++; $display("FAIL reset_ctl_a: got %b want 00000", {a_acc_en, a_s_ready, a_mv, a_done, a_busy});
        end
        total++;
        if ({a_m1, a_m2, a_m3, a_m4} !== 104'd0) begin
            bad++; $display("FAIL reset_mean_a: got %h want 0", {a_m1, a_m2, a_m3, a_m4});
        end
        total++;
        if ({b_acc_en, b_s_ready, b_mv, b_done, b_busy} !== 5'b0) begin
            bad++; $display("FAIL reset_ctl_b: got %b want 00000", {b_acc_en, b_s_ready, b_mv, b_done, b_busy});
        end
        total++;
        if ({b_m1, b_m2, b_m3, b_m4} !== 104'd0) begin
            bad++; $display("FAIL reset_mean_b: got %h want 0", {b_m1, b_m2, b_m3, b_m4});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One pass on instance A using smp[][]; vpat gives s_valid per ACC cycle
    // (bit 0 first) for the first vlen cycles, then s_valid stays high.
    task automatic run_pass_a(input bit from_done, input logic [6:0] vpat, input int vlen,
                              input int exp_lat, input int exp_sum1);
        int                 c0, p, k, lat;
        bit                 v, seen;
        longint             s;
        logic signed [25:0] m[4];
        logic [103:0]       e;
        for (int ch = 0; ch < 4; ch++) begin
            s = 0;
            for (int i = 0; i < 4; i++) s = s + longint'(smp[ch][i]);
            m[ch] = 26'(floordiv(s, 4));
        end
        qa.push_back({m[0], m[1], m[2], m[3]});

        @(negedge clk);
        a_start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        a_start = 1'b0;
        if (from_done) begin
            #1;
            total++;
            if ({a_acc_en, a_busy, a_mv, a_s_ready} !== 4'b0100) begin
                bad++; $display("FAIL clr_ctl: got %b want 0100", {a_acc_en, a_busy, a_mv, a_s_ready});
            end
            total++;
            if ({a_m1, a_m2, a_m3, a_m4} !== last_a) begin
                bad++; $display("FAIL clr_mean_kept: got %h want %h", {a_m1, a_m2, a_m3, a_m4}, last_a);
            end
            @(negedge clk);
            total++;
            if (a_sum1 !== 40'sd0) begin
                bad++; $display("FAIL clr_sum: got %0d want 0", a_sum1);
            end
        end

        k = 0; p = 0;
        while (k < 4 && p < 40) begin
            v = (p < vlen) ? vpat[p] : 1'b1;
            p++;
            a_s_valid = v;
            a_x1 = 26'(smp[0][k]); a_x2 = 26'(smp[1][k]);
            a_x3 = 26'(smp[2][k]); a_x4 = 26'(smp[3][k]);
            #1;
            total++;
            if (a_s_ready !== 1'b1) begin
                bad++; $display("FAIL acc_ready: cyc=%0d got %b want 1", cyc, a_s_ready);
            end
            total++;
            if (a_ax1 !== (v ? 26'(smp[0][k]) : 26'sd0)) begin
                bad++; $display("FAIL acc_x1: cyc=%0d got %0d want %0d", cyc, a_ax1, v ? smp[0][k] : 0);
            end
            if (v) k++;
            @(negedge clk);
        end
        a_s_valid = 1'b0;
        a_x1 = 0; a_x2 = 0; a_x3 = 0; a_x4 = 0;
        #1;
        total++;
        if ({a_s_ready, a_acc_en, a_busy} !== 3'b011) begin
            bad++; $display("FAIL flush_ctl: got %b want 011", {a_s_ready, a_acc_en, a_busy});
        end
        total++;
        if (a_sum1 !== 40'(exp_sum1)) begin
            bad++; $display("FAIL flush_sum1: got %0d want %0d", a_sum1, exp_sum1);
        end

        seen = 0; lat = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            if (a_done === 1'b1) begin
                seen = 1; lat = cyc - c0;
            end else begin
                @(negedge clk);
            end
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL done_timeout_a: got none want pulse");
        end else begin
            if (lat !== exp_lat) begin
                bad++; $display("FAIL done_latency_a: got %0d want %0d", lat, exp_lat);
            end
            total++;
            if (a_mv !== 1'b1) begin
                bad++; $display("FAIL mean_valid_a: got %b want 1", a_mv);
            end
            total++;
            if (qa.size() == 0) begin
                bad++; $display("FAIL sb_empty_a: got 0 entries want 1");
            end else begin
                e = qa.pop_front();
                last_a = e;
                if ({a_m1, a_m2, a_m3, a_m4} !== e) begin
                    bad++; $display("FAIL means_a: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                                    a_m1, a_m2, a_m3, a_m4, $signed(e[103:78]), $signed(e[77:52]),
                                    $signed(e[51:26]), $signed(e[25:0]));
                end
            end
            @(negedge clk);
            total++;
            if ({a_done, a_mv} !== 2'b01) begin
                bad++; $display("FAIL done_pulse_a: got %b want 01", {a_done, a_mv});
            end
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin
            smp[0][i] = 10 * (i + 1);
            smp[1][i] = (i == 0) ? -1 : -2;
            smp[2][i] = 5;
            smp[3][i] = 0;
        end
        run_pass_a(1'b0, 7'h7f, 0, 6, 100);
    endtask

    task automatic test_restart();
        for (int ch = 0; ch < 4; ch++)
            for (int i = 0; i < 4; i++) smp[ch][i] = 4;
        run_pass_a(1'b1, 7'h7f, 0, 7, 16);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) begin
            smp[0][i] = 10 * (i + 1);
            smp[1][i] = (i == 0) ? -1 : -2;
            smp[2][i] = 5;
            smp[3][i] = 0;
        end
        run_pass_a(1'b1, 7'b1011001, 7, 10, 100);
    endtask

    task automatic test_abort();
        bit saw_done;
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;          // CLR
        @(negedge clk); a_s_valid = 1'b1; a_x1 = 26'sd7;
        @(negedge clk);
        @(negedge clk); a_abort = 1'b1;          // two samples in, abort with a third offered
        @(negedge clk); a_abort = 1'b0; a_s_valid = 1'b0; a_x1 = 0;
        #1;
        total++;
        if ({a_busy, a_acc_en, a_s_ready, a_mv} !== 4'b0000) begin
            bad++; $display("FAIL abort_idle: got %b want 0000", {a_busy, a_acc_en, a_s_ready, a_mv});
        end
        saw_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (a_done === 1'b1) saw_done = 1;
            @(negedge clk);
        end
        total++;
        if (saw_done) begin
            bad++; $display("FAIL abort_no_done: got pulse want none");
        end
        total++;
        if (a_sum1 !== 40'sd0) begin
            bad++; $display("FAIL abort_sum: got %0d want 0", a_sum1);
        end
        a_start = 1'b1; a_abort = 1'b1;
        @(negedge clk);
        a_start = 1'b0; a_abort = 1'b0;
        #1;
        total++;
        if ({a_busy, a_s_ready, a_acc_en} !== 3'b000) begin
            bad++; $display("FAIL start_abort: got %b want 000", {a_busy, a_s_ready, a_acc_en});
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0; a_s_valid = 1'b1; a_x1 = 26'sd3;
        @(negedge clk);
        #1;
        total++;
        if (a_busy !== 1'b1) begin
            bad++; $display("FAIL mid_busy: got %b want 1", a_busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({a_busy, a_acc_en, a_mv} !== 3'b000 || {a_m1, a_m2, a_m3, a_m4} !== 104'd0) begin
            bad++; $display("FAIL mid_reset: got ctl=%b means=%h want ctl=000 means=0",
                            {a_busy, a_acc_en, a_mv}, {a_m1, a_m2, a_m3, a_m4});
        end
        @(negedge clk);
        rst_n = 1'b1; a_s_valid = 1'b0; a_x1 = 0;
        @(negedge clk);
    endtask

    // Full-length pass on instance B with the same value on every channel.
    task automatic run_pass_b(input bit from_done, input logic signed [25:0] val, input int exp_lat);
        int                 c0, p, k, lat, ready_errs;
        bit                 seen;
        logic signed [25:0] m;
        logic [103:0]       e;
        m = 26'(floordiv(longint'(val) * NB, NB));
        qb.push_back({m, m, m, m});

        @(negedge clk);
        b_start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        b_start = 1'b0;
        if (from_done) begin
            #1;
            total++;
            if (b_acc_en !== 1'b0) begin
                bad++; $display("FAIL clr_b: got %b want 0", b_acc_en);
            end
            @(negedge clk);
        end
        k = 0; p = 0; ready_errs = 0;
        b_s_valid = 1'b1;
        b_x1 = val; b_x2 = val; b_x3 = val; b_x4 = val;
        while (k < NB && p < NB + 20) begin
            #1;
            if (b_s_ready === 1'b1) k++;
            else ready_errs++;
            p++;
            @(negedge clk);
        end
        b_s_valid = 1'b0;
        b_x1 = 0; b_x2 = 0; b_x3 = 0; b_x4 = 0;
        total++;
        if (ready_errs != 0) begin
            bad++; $display("FAIL ready_b: got %0d stalled cycles want 0", ready_errs);
        end
        seen = 0; lat = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            if (b_done === 1'b1) begin
                seen = 1; lat = cyc - c0;
            end else begin
                @(negedge clk);
            end
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL done_timeout_b: got none want pulse");
        end else begin
            if (lat !== exp_lat) begin
                bad++; $display("FAIL done_latency_b: got %0d want %0d", lat, exp_lat);
            end
            total++;
            if (qb.size() == 0) begin
                bad++; $display("FAIL sb_empty_b: got 0 entries want 1");
            end else begin
                e = qb.pop_front();
                if ({b_m1, b_m2, b_m3, b_m4} !== e || b_mv !== 1'b1) begin
                    bad++; $display("FAIL means_b: got %0d %0d %0d %0d mv=%b want %0d x4 mv=1",
                                    b_m1, b_m2, b_m3, b_m4, b_mv, $signed(e[25:0]));
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_full_range();
        run_pass_b(1'b0, -26'sd33554432, NB + 2);
        run_pass_b(1'b1, 26'sd33554431, NB + 3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        last_a = '0;
        test_reset();
        test_basic();
        test_restart();
        test_stall();
        test_abort();
        test_reset_mid();
        test_full_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cen_mean_ctrl.md
Name: cen_mean_ctrl

Overview:
Sequencer for the four-channel centering accumulator (enable-cleared, adds every enabled cycle) in the FastICA front end. Accepts a stream of 4-channel samples via valid/ready and holds the accumulator enable high for one full pass of 2^LOG2N samples. It zeroes the accumulator inputs on stall cycles, then converts the 40-bit sums into 26-bit per-channel means for the downstream centering/whitening stage.

Parameters:
DW, 26, sample width per channel (signed)
SW, 40, accumulator sum width (signed)
LOG2N, 8, log2 of samples per pass; legal range 1..(SW-DW)=14, which guarantees no sum overflow

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a pass; sampled in IDLE or DONE only
abort  in  1  cancel pass; return to IDLE
s_valid  in  1  sample valid
s_ready  out  1  controller accepts sample
s_x1..s_x4  in  DW each  signed input samples
acc_en  out  1  drives accumulator En (low = clear)
acc_x1..acc_x4  out  DW each  signed accumulator inputs (gated)
acc_sum1..acc_sum4  in  SW each  signed accumulator sums
mean1..mean4  out  DW each  signed per-channel mean, registered
mean_valid  out  1  means valid (level)
done  out  1  one-cycle pulse on pass completion
busy  out  1  high in CLR, ACC, FLUSH

Behaviour:
- States: IDLE, CLR, ACC, FLUSH, DONE. Sample counter cnt is LOG2N+1 bits wide.
- Reset (async, rst_n low): state=IDLE, cnt=0, mean1..4=0, mean_valid=0, done=0. acc_en=0 follows from state.
- acc_en=1 in ACC, FLUSH and DONE; 0 in IDLE and CLR. Accumulator clears whenever acc_en=0.
- s_ready=1 only in ACC. The transfer is s_valid&s_ready.
- acc_xk is combinational: s_xk during a transfer, else 0. This keeps the sums frozen on stall, FLUSH and DONE cycles.
- IDLE: start=1 -> ACC, cnt=0.
- ACC:
  - Each transfer increments cnt.
  - The transfer that makes cnt reach 2^LOG2N moves to FLUSH; no further samples are accepted.
- FLUSH (1 cycle):
  - The sums now include the last sample.
  - Register meank = acc_sumk[LOG2N+DW-1 : LOG2N], an arithmetic shift right with floor rounding. No saturation is needed.
  - Next state DONE.
- DONE:
  - mean_valid=1, held until leaving DONE. done=1 in the first DONE cycle only.
  - Sums stay stable and readable.
  - start=1 -> CLR with mean_valid=0. Means keep their old values until overwritten.
- CLR (1 cycle): acc_en=0 clears sums; cnt=0; next state ACC.
- abort=1 in any state -> IDLE next cycle. Effects: cnt=0, mean_valid=0, done=0, sums cleared via acc_en=0. abort has priority over start and over the final transfer.
- start outside IDLE/DONE is ignored.
- Latency with s_valid held high:
  - start at cycle 0 -> ACC at cycles 1..N.
  - FLUSH at N+1.
  - DONE, mean_valid and done at N+2.
  - From DONE, a restart adds 1 cycle (CLR).
- Simultaneous start and abort: abort wins.
- Stall: s_valid=0 in ACC holds cnt and the sums; there is no timeout.

Test Plan:
- LOG2N=2, ch1 samples 10,20,30,40 with s_valid continuous; start at cycle 0 -> ACC cycles 1-4, acc_sum1=100, mean1=25, done pulse and mean_valid at cycle 6.
- LOG2N=2, ch2 samples -1,-2,-2,-2 -> sum -7, mean2=-2 (floor); ch3 all 5 -> mean3=5; ch4 all 0 -> mean4=0.
- Same ch1 data with s_valid toggling 1,0,0,1,1,0,1 -> acc_x1=0 on gap cycles, s_ready=1 throughout ACC, mean1=25, done delayed by 3 cycles versus the first test.
- From DONE, pulse start -> one CLR cycle with acc_en=0, sums return to 0; second pass with samples 4,4,4,4 -> mean1=4, first-pass results gone.
- abort after 2 of 4 samples -> IDLE next cycle, acc_en=0, no done pulse. rst_n low mid-ACC -> immediate IDLE, means=0, mean_valid=0.
- LOG2N=14, all samples -2^25 on every channel -> no overflow, means=-2^25. All samples 2^25-1 -> means=2^25-1.
